rbcp_reg_responder: RTL and testbench

RBCP_REG_RESPONDER -- requirements
Module: rbcp_reg_responder

---
 rtl/rbcp_reg_pkg.sv | 26 ++
 rtl/rbcp_reg_responder_if.sv | 23 ++
 rtl/rbcp_reg_responder.sv | 117 +++++++++++
 tb/tb_rbcp_reg_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rbcp_reg_pkg.sv
// RBCP register responder shared definitions.
// Address map offsets, FSM states and a status byte selector.
package rbcp_reg_pkg;

    localparam logic [3:0] OFS_CTRL0 = 4'h0;
    localparam logic [3:0] OFS_STAT0 = 4'h8;
    localparam logic [3:0] OFS_PULSE = 4'hC;
    localparam logic [3:0] OFS_LAST  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ACK
    } state_t;

    // Byte i of a 32-bit word, byte 0 being the most significant.
    function automatic logic [7:0] word_byte(logic [31:0] w, logic [1:0] i);
        unique case (i)
            2'd0: word_byte = w[31:24];
            2'd1: word_byte = w[23:16];
            2'd2: word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rbcp_reg_responder_if.sv
// RBCP host bus bundle.
// The host drives the access, the responder returns ACK and read data.
interface rbcp_reg_responder_if;

    logic        act;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic        re;
    logic        ack;
    logic [7:0]  rd;

    modport master (
        output act, addr, we, wd, re,
        input  ack, rd
    );

    modport slave (
        input  act, addr, we, wd, re,
        output ack, rd
    );

endinterface

// File: rtl/rbcp_reg_responder.sv
// RBCP register responder: 8 control bytes, 4 status bytes, pulse register.
// Flat IDLE/EXEC/ACK FSM with every output registered.
module rbcp_reg_responder
    import rbcp_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [63:0] RW_DEFAULT = 64'h0
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTs,
    input  logic        RBCP_ACT,
    input  logic [31:0] RBCP_ADDR,
    input  logic        RBCP_WE,
    input  logic [7:0]  RBCP_WD,
    input  logic        RBCP_RE,
    output logic        RBCP_ACK,
    output logic [7:0]  RBCP_RD,
    input  logic [31:0] STATUS_IN,
    output logic [63:0] CTRL_OUT,
    output logic [7:0]  PULSE_OUT
);

    state_t      state_q;
    logic [3:0]  ofs_q;
    logic [7:0]  wd_q;
    logic        wr_q;
    logic [7:0]  ctrl_q [8];
    logic [31:0] shadow_q;
    logic        ack_q;
    logic [7:0]  rd_q;
    logic [7:0]  pulse_q;

    logic [31:0] ofs_d;
    logic        hit_d;
    logic [7:0]  rdsel_d;

    // Decode the incoming strobe and select read data for the latched offset.
    always_comb begin
        ofs_d = RBCP_ADDR - BASE_ADDR;
        hit_d = RBCP_ACT && (RBCP_WE || RBCP_RE)
                && (ofs_d <= {28'h0, OFS_LAST});
        rdsel_d = 8'h00;
        if (ofs_q < OFS_STAT0) begin
            rdsel_d = ctrl_q[ofs_q[2:0]];
        end else if (ofs_q == OFS_STAT0) begin
            // Same value the shadow captures this cycle.
            rdsel_d = STATUS_IN[31:24];
        end else if (ofs_q < OFS_PULSE) begin
            rdsel_d = word_byte(shadow_q, ofs_q[1:0]);
        end
    end

    // Access FSM; registers, ACK, read data and pulses all update here.
    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            state_q  <= ST_IDLE;
            ofs_q    <= OFS_CTRL0;
            wd_q     <= 8'h00;
            wr_q     <= 1'b0;
            shadow_q <= 32'h0;
            ack_q    <= 1'b0;
            rd_q     <= 8'h00;
            pulse_q  <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                ctrl_q[k] <= RW_DEFAULT[63-8*k -: 8];
            end
        end else begin
            ack_q   <= 1'b0;
            rd_q    <= 8'h00;
            pulse_q <= 8'h00;
            unique case (state_q)
                ST_IDLE: begin
                    if (hit_d) begin
                        ofs_q   <= ofs_d[3:0];
                        wd_q    <= RBCP_WD;
                        wr_q    <= RBCP_WE;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!RBCP_ACT) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        if (wr_q) begin
                            if (ofs_q < OFS_STAT0) begin
                                ctrl_q[ofs_q[2:0]] <= wd_q;
                            end else if (ofs_q == OFS_PULSE) begin
                                pulse_q <= wd_q;
                            end
                        end else begin
                            rd_q <= rdsel_d;
                            if (ofs_q == OFS_STAT0) begin
                                shadow_q <= STATUS_IN;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pack the control bytes big-endian onto the output.
    always_comb begin
        CTRL_OUT = 64'h0;
        for (int k = 0; k < 8; k++) begin
            CTRL_OUT[63-8*k -: 8] = ctrl_q[k];
        end
    end

    assign RBCP_ACK  = ack_q;
    assign RBCP_RD   = rd_q;
    assign PULSE_OUT = pulse_q;

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Directed bench for rbcp_reg_responder.
// Table of single accesses plus hand sequences for abort, range and reset.
module tb_rbcp_reg_responder;
    import rbcp_reg_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [63:0] DEF  = 64'h0102_0304_0506_0708;
    localparam logic [63:0] C1   = 64'h0102_03A5_0506_0708;
    localparam logic [63:0] C2   = 64'h0102_03A5_0506_073C;
    localparam logic [63:0] C3   = 64'h0177_03A5_0506_073C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] status = 32'h0;
    logic [63:0] ctrl;
    logic [7:0]  pulse;

    rbcp_reg_responder_if bus ();

    rbcp_reg_responder #(
        .BASE_ADDR (BASE),
        .RW_DEFAULT(DEF)
    ) dut (
        .XGMII_CLOCK(clk),
        .RSTs       (rst),
        .RBCP_ACT   (bus.act),
        .RBCP_ADDR  (bus.addr),
        .RBCP_WE    (bus.we),
        .RBCP_WD    (bus.wd),
        .RBCP_RE    (bus.re),
        .RBCP_ACK   (bus.ack),
        .RBCP_RD    (bus.rd),
        .STATUS_IN  (status),
        .CTRL_OUT   (ctrl),
        .PULSE_OUT  (pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  ofs;
        logic [7:0]  wd;
        logic [31:0] stat;
        logic [7:0]  exp_rd;
        logic [63:0] exp_ctrl;
        logic [7:0]  exp_pulse;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Legal access; samples N+1, N+2 and N+3 mid-cycle.
    task automatic run_one(input logic [31:0] addr, input logic we,
                           input logic re, input logic [7:0] wd,
                           output logic a1, output logic [63:0] c1,
                           output logic a2, output logic [7:0] r2,
                           output logic [63:0] c2, output logic [7:0] p2,
                           output logic a3, output logic [7:0] p3);
        @(posedge clk); #1;
        bus.act = 1'b1; bus.addr = addr;
        bus.we = we; bus.re = re; bus.wd = wd;
        @(posedge clk); #1;
        bus.we = 1'b0; bus.re = 1'b0;
        @(negedge clk);
        a1 = bus.ack; c1 = ctrl;
        @(negedge clk);
        a2 = bus.ack; r2 = bus.rd; c2 = ctrl; p2 = pulse;
        @(negedge clk);
        a3 = bus.ack; p3 = pulse;
        bus.act = 1'b0;
    endtask

    task automatic watch_no_ack(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.ack) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    vec_t vec [17];

    initial begin
        logic        a1, a2, a3;
        logic [7:0]  r2, p2, p3;
        logic [63:0] c1, c2, prev;

        vec[0]  = '{1'b1, 1'b0, 8'h03, 8'hA5, 32'h0, 8'h00, C1, 8'h00};
        vec[1]  = '{1'b0, 1'b1, 8'h03, 8'h00, 32'h0, 8'hA5, C1, 8'h00};
        vec[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 32'h0, 8'h01, C1, 8'h00};
        vec[3]  = '{1'b1, 1'b0, 8'h07, 8'h3C, 32'h0, 8'h00, C2, 8'h00};
        vec[4]  = '{1'b1, 1'b1, 8'h01, 8'h77, 32'h0, 8'h00, C3, 8'h00};
        vec[5]  = '{1'b0, 1'b1, 8'h08, 8'h00, 32'h11223344, 8'h11, C3, 8'h00};
        vec[6]  = '{1'b0, 1'b1, 8'h09, 8'h00, 32'hFFFFFFFF, 8'h22, C3, 8'h00};
        vec[7]  = '{1'b0, 1'b1, 8'h0A, 8'h00, 32'hFFFFFFFF, 8'h33, C3, 8'h00};
        vec[8]  = '{1'b0, 1'b1, 8'h0B, 8'h00, 32'hFFFFFFFF, 8'h44, C3, 8'h00};
        vec[9]  = '{1'b1, 1'b0, 8'h0C, 8'h81, 32'hFFFFFFFF, 8'h00, C3, 8'h81};
        vec[10] = '{1'b0, 1'b1, 8'h0C, 8'h00, 32'hFFFFFFFF, 8'h00, C3, 8'h00};
        vec[11] = '{1'b1, 1'b0, 8'h09, 8'hEE, 32'hFFFFFFFF, 8'h00, C3, 8'h00};
        vec[12] = '{1'b1, 1'b0, 8'h0E, 8'h99, 32'hFFFFFFFF, 8'h00, C3, 8'h00};
        vec[13] = '{1'b0, 1'b1, 8'h0E, 8'h00, 32'hFFFFFFFF, 8'h00, C3, 8'h00};
        vec[14] = '{1'b0, 1'b1, 8'h08, 8'h00, 32'hFFFFFFFF, 8'hFF, C3, 8'h00};
        vec[15] = '{1'b0, 1'b1, 8'h0B, 8'h00, 32'h12345678, 8'hFF, C3, 8'h00};
        vec[16] = '{1'b0, 1'b1, 8'h06, 8'h00, 32'h0, 8'h07, C3, 8'h00};

        bus.act = 1'b0; bus.addr = 32'h0; bus.we = 1'b0;
        bus.re = 1'b0; bus.wd = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ack", 64'(bus.ack), 64'd0);
        chk("rst rd", 64'(bus.rd), 64'h00);
        chk("rst pulse", 64'(pulse), 64'h00);
        chk("rst ctrl", ctrl, DEF);
        @(posedge clk); #1;
        rst = 1'b0;

        prev = DEF;
        for (int i = 0; i < 17; i++) begin
            status = vec[i].stat;
            run_one(BASE + 32'(vec[i].ofs), vec[i].we, vec[i].re, vec[i].wd,
                    a1, c1, a2, r2, c2, p2, a3, p3);
            chk($sformatf("v%0d ack N+1", i), 64'(a1), 64'd0);
            chk($sformatf("v%0d ctrl N+1", i), c1, prev);
            chk($sformatf("v%0d ack N+2", i), 64'(a2), 64'd1);
            chk($sformatf("v%0d rd", i), 64'(r2), 64'(vec[i].exp_rd));
            chk($sformatf("v%0d ctrl", i), c2, vec[i].exp_ctrl);
            chk($sformatf("v%0d pulse N+2", i), 64'(p2), 64'(vec[i].exp_pulse));
            chk($sformatf("v%0d ack N+3", i), 64'(a3), 64'd0);
            chk($sformatf("v%0d pulse N+3", i), 64'(p3), 64'h00);
            prev = vec[i].exp_ctrl;
        end

        // Out-of-range reads above and below the window.
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            bus.act = 1'b1;
            bus.addr = (j == 0) ? BASE + 32'h10 : BASE - 32'h1;
            bus.re = 1'b1;
            @(posedge clk); #1;
            bus.re = 1'b0;
            watch_no_ack($sformatf("oor%0d ack", j), 16);
            chk($sformatf("oor%0d idle", j), 64'(dut.state_q), 64'(ST_IDLE));
            bus.act = 1'b0;
        end

        // Strobe without ACT.
        @(posedge clk); #1;
        bus.addr = BASE + 32'h3; bus.re = 1'b1;
        @(posedge clk); #1;
        bus.re = 1'b0;
        watch_no_ack("noact ack", 4);

        // Abort: ACT drops during EXEC.
        @(posedge clk); #1;
        bus.act = 1'b1; bus.addr = BASE; bus.we = 1'b1; bus.wd = 8'h55;
        @(posedge clk); #1;
        bus.we = 1'b0; bus.act = 1'b0;
        watch_no_ack("abort ack", 8);
        chk("abort ctrl", ctrl, C3);
        run_one(BASE, 1'b0, 1'b1, 8'h00, a1, c1, a2, r2, c2, p2, a3, p3);
        chk("post-abort ack", 64'(a2), 64'd1);
        chk("post-abort rd", 64'(r2), 64'h01);

        // Reset arriving in the EXEC cycle of a write.
        @(posedge clk); #1;
        bus.act = 1'b1; bus.addr = BASE + 32'h2; bus.we = 1'b1; bus.wd = 8'hDD;
        @(posedge clk); #1;
        bus.we = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        watch_no_ack("rstmid ack", 6);
        chk("rstmid ctrl", ctrl, DEF);
        chk("rstmid pulse", 64'(pulse), 64'h00);
        bus.act = 1'b0;

        // Shadow cleared by reset.
        status = 32'hFFFFFFFF;
        run_one(BASE + 32'h9, 1'b0, 1'b1, 8'h00,
                a1, c1, a2, r2, c2, p2, a3, p3);
        chk("shadow rst ack", 64'(a2), 64'd1);
        chk("shadow rst rd", 64'(r2), 64'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
